// File: rtl/processor_mem_copy_master_pkg.sv
// Shared state encoding and default widths for the on-chip memory copy master.
package processor_mem_copy_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        DONE
    } copy_state_t;

endpackage

// File: rtl/processor_mem_copy_master_if.sv
// Avalon-MM master/slave bundle between the copy master and the RAM slave port.
interface processor_mem_copy_master_if
    import processor_mem_copy_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_read,
        output avm_write,
        output avm_byteenable,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_read,
        input  avm_write,
        input  avm_byteenable,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/processor_mem_copy_master.sv
// Copies a block of words between two addresses of a single-port RAM, one read
// then one write per word, in strictly ascending order with wrapping pointers.
module processor_mem_copy_master
    import processor_mem_copy_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     words_done,
    processor_mem_copy_master_if.master avm
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int CNT_W = ADDR_W + 1;

    copy_state_t        state;
    logic [ADDR_W-1:0]  src_ptr;
    logic [ADDR_W-1:0]  dst_ptr;
    logic [CNT_W-1:0]   remaining;
    logic [LAT_W-1:0]   lat_cnt;
    logic [DATA_W-1:0]  hold_q;
    logic [ADDR_W-1:0]  address_q;
    logic               cs_q;
    logic               read_q;
    logic               write_q;

    assign avm.avm_address    = address_q;
    assign avm.avm_chipselect = cs_q;
    assign avm.avm_read       = read_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_byteenable = '1;
    assign avm.avm_writedata  = hold_q;

    // Bus strobes are set up one state ahead so every output leaves a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            lat_cnt    <= '0;
            hold_q     <= '0;
            address_q  <= '0;
            cs_q       <= 1'b0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_done <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr    <= src_addr;
                        dst_ptr    <= dst_addr;
                        remaining  <= length;
                        words_done <= '0;
                        busy       <= 1'b1;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RD;
                            cs_q      <= 1'b1;
                            read_q    <= 1'b1;
                            address_q <= src_addr;
                        end
                    end
                end

                RD: begin
                    if (!avm.avm_waitrequest) begin
                        cs_q    <= 1'b0;
                        read_q  <= 1'b0;
                        lat_cnt <= LAT_W'(READ_LATENCY);
                        state   <= RWAIT;
                    end
                end

                RWAIT: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        hold_q    <= avm.avm_readdata;
                        cs_q      <= 1'b1;
                        write_q   <= 1'b1;
                        address_q <= dst_ptr;
                        state     <= WR;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end

                WR: begin
                    if (!avm.avm_waitrequest) begin
                        src_ptr    <= src_ptr + ADDR_W'(1);
                        dst_ptr    <= dst_ptr + ADDR_W'(1);
                        words_done <= words_done + CNT_W'(1);
                        remaining  <= remaining - CNT_W'(1);
                        write_q    <= 1'b0;
                        if (remaining == CNT_W'(1)) begin
                            cs_q  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            read_q    <= 1'b1;
                            address_q <= src_ptr + ADDR_W'(1);
                            state     <= RD;
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_processor_mem_copy_master.sv
// Bench for the copy master: RAM slave with injectable stalls, plus a copy-order
// model of expected bus transfers, memory contents and completion cycle.
module tb_processor_mem_copy_master;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int RL     = 1;
    localparam int DEPTH  = 2048;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_done;

    processor_mem_copy_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    processor_mem_copy_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .READ_LATENCY(RL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .avm        (bus.master)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc = 0;
    logic preload;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // RAM slave: registered address, unregistered q, stalls on request
    logic [DATA_W-1:0] ram [DEPTH];
    logic [ADDR_W-1:0] rd_addr_q;
    int                rd_cfg, wr_cfg, rd_used, wr_used;
    logic              rnd_mode, rnd_bit;

    assign bus.avm_readdata    = ram[rd_addr_q];
    assign bus.avm_waitrequest = (bus.avm_read  && (rd_used < rd_cfg || rnd_bit)) ||
                                 (bus.avm_write && (wr_used < wr_cfg || rnd_bit));

    always @(posedge clk) begin
        if (preload)
            for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hA000_0000 + 32'(i);
        if (bus.avm_chipselect && bus.avm_write && !bus.avm_waitrequest)
            ram[bus.avm_address] <= bus.avm_writedata;
        if (bus.avm_chipselect && bus.avm_read && !bus.avm_waitrequest)
            rd_addr_q <= bus.avm_address;
        if (start) begin
            rd_used <= 0;
            wr_used <= 0;
        end else begin
            if (bus.avm_read && rd_used < rd_cfg) rd_used <= rd_used + 1;
            if (bus.avm_write && wr_used < wr_cfg) wr_used <= wr_used + 1;
        end
        rnd_bit <= rnd_mode && ($urandom_range(0, 3) == 0);
    end

    // Model: a copy is a list of reads and writes, finishing 2+RL cycles per word plus stalls
    logic [DATA_W-1:0] mdl [DEPTH];
    logic [DATA_W-1:0] tmp [DEPTH];
    logic [ADDR_W-1:0] rd_q [$];
    logic [ADDR_W-1:0] rd_log [$];
    wr_t               wr_q [$];
    wr_t               exp_w;
    logic              mdl_active = 1'b0;
    logic              accept, stall_now, prev_stall;
    logic [ADDR_W-1:0] prev_address, s_a, d_a;
    logic [DATA_W-1:0] prev_wdata;
    logic              prev_read, prev_write;
    int                start_cyc, mdl_n, stalls, wr_count, exp_done, last_done_rel, cs_seen;

    always @(negedge clk) begin
        if (preload)
            for (int i = 0; i < DEPTH; i++) mdl[i] = 32'hA000_0000 + 32'(i);
        if (!reset_n) begin
            mdl_active = 1'b0;
            rd_q.delete();
            wr_q.delete();
            wr_count   = 0;
            prev_stall = 1'b0;
        end else begin
            accept    = start && !mdl_active;
            stall_now = bus.avm_chipselect && bus.avm_waitrequest;
            checkOutput("rd_wr_exclusive", 64'(bus.avm_read && bus.avm_write), 64'd0);
            checkOutput("cs_is_rd_or_wr", 64'(bus.avm_chipselect), 64'(bus.avm_read | bus.avm_write));
            checkOutput("byteenable", 64'(bus.avm_byteenable), 64'hF);
            if (prev_stall) begin
                checkOutput("stall_address", 64'(bus.avm_address), 64'(prev_address));
                checkOutput("stall_read", 64'(bus.avm_read), 64'(prev_read));
                checkOutput("stall_write", 64'(bus.avm_write), 64'(prev_write));
                checkOutput("stall_wdata", 64'(bus.avm_writedata), 64'(prev_wdata));
            end
            if (bus.avm_chipselect) cs_seen++;
            if (mdl_active) begin
                if (stall_now) stalls++;
                exp_done = start_cyc + 1 + mdl_n * (2 + RL) + stalls;
                checkOutput("busy", 64'(busy), 64'd1);
                checkOutput("done", 64'(done), 64'(cyc == exp_done));
                checkOutput("words_done", 64'(words_done), 64'(wr_count));
                if (bus.avm_chipselect && bus.avm_read && !bus.avm_waitrequest) begin
                    rd_log.push_back(bus.avm_address);
                    if (rd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL extra_read: got read at 0x%0h, required no read (cycle %0d)", bus.avm_address, cyc);
                    end else begin
                        checkOutput("read_address", 64'(bus.avm_address), 64'(rd_q.pop_front()));
                    end
                end
                if (bus.avm_chipselect && bus.avm_write && !bus.avm_waitrequest) begin
                    if (wr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL extra_write: got write at 0x%0h, required no write (cycle %0d)", bus.avm_address, cyc);
                    end else begin
                        exp_w = wr_q.pop_front();
                        checkOutput("write_address", 64'(bus.avm_address), 64'(exp_w.addr));
                        checkOutput("write_data", 64'(bus.avm_writedata), 64'(exp_w.data));
                        mdl[exp_w.addr] = exp_w.data;
                        wr_count++;
                    end
                end
                if (cyc == exp_done) begin
                    mdl_active    = 1'b0;
                    last_done_rel = cyc - start_cyc;
                    checkOutput("reads_left", 64'(rd_q.size()), 64'd0);
                    checkOutput("writes_left", 64'(wr_q.size()), 64'd0);
                end
            end else begin
                checkOutput("idle_busy", 64'(busy), 64'd0);
                checkOutput("idle_done", 64'(done), 64'd0);
                checkOutput("idle_cs", 64'(bus.avm_chipselect), 64'd0);
                checkOutput("idle_words_done", 64'(words_done), 64'(wr_count));
            end
            if (accept) begin
                start_cyc     = cyc;
                mdl_n         = int'(length);
                stalls        = 0;
                wr_count      = 0;
                cs_seen       = 0;
                last_done_rel = -1;
                rd_q.delete();
                wr_q.delete();
                rd_log.delete();
                tmp = mdl;
                for (int i = 0; i < mdl_n; i++) begin
                    s_a = src_addr + ADDR_W'(i);
                    d_a = dst_addr + ADDR_W'(i);
                    rd_q.push_back(s_a);
                    wr_q.push_back(wr_t'{addr: d_a, data: tmp[s_a]});
                    tmp[d_a] = tmp[s_a];
                end
                mdl_active = 1'b1;
            end
            prev_stall   = stall_now;
            prev_address = bus.avm_address;
            prev_read    = bus.avm_read;
            prev_write   = bus.avm_write;
            prev_wdata   = bus.avm_writedata;
        end
    end

    task automatic applyStimulus(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                                 input logic [ADDR_W:0] n, input int rds, input int wrs,
                                 input logic rnd, input int restart_at, input int reset_at);
        int budget;
        budget = 16 * int'(n) + 200;
        @(posedge clk); #1;
        rd_cfg   = rds;
        wr_cfg   = wrs;
        rnd_mode = rnd;
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            if (k == restart_at) begin
                start    = 1'b1;
                src_addr = 11'h400;
                dst_addr = 11'h500;
                length   = 12'd7;
            end else begin
                start = 1'b0;
            end
            if (k == reset_at) begin
                reset_n = 1'b0;
                #1;
                checkOutput("rst_busy", 64'(busy), 64'd0);
                checkOutput("rst_cs", 64'(bus.avm_chipselect), 64'd0);
                checkOutput("rst_read", 64'(bus.avm_read), 64'd0);
                checkOutput("rst_done", 64'(done), 64'd0);
                checkOutput("rst_words_done", 64'(words_done), 64'd0);
                repeat (2) @(posedge clk);
                #1 reset_n = 1'b1;
            end
            if (!mdl_active && !start) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("[TB] FAIL timeout: busy=%0b after %0d cycles, required idle", busy, budget);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    logic [ADDR_W-1:0] exp_wrap [4];
    logic [ADDR_W-1:0] rs, rdst;
    logic [ADDR_W:0]   rn;
    int                mism;

    initial begin
        checks   = 0;
        errors   = 0;
        preload  = 1'b1;
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        length   = '0;
        rd_cfg   = 0;
        wr_cfg   = 0;
        rnd_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_words_done", 64'(words_done), 64'd0);
        checkOutput("reset_cs", 64'(bus.avm_chipselect), 64'd0);
        checkOutput("reset_read", 64'(bus.avm_read), 64'd0);
        checkOutput("reset_write", 64'(bus.avm_write), 64'd0);
        checkOutput("reset_address", 64'(bus.avm_address), 64'd0);
        checkOutput("reset_wdata", 64'(bus.avm_writedata), 64'd0);
        checkOutput("reset_byteenable", 64'(bus.avm_byteenable), 64'hF);
        reset_n = 1'b1;

        $display("[TB] basic copy 0x010 -> 0x100, 4 words");
        applyStimulus(11'h010, 11'h100, 12'd4, 0, 0, 1'b0, 0, 0);
        checkOutput("basic_done_cycle", 64'(last_done_rel), 64'd13);
        checkOutput("basic_words_done", 64'(words_done), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("basic_mem", 64'(ram[11'h100 + 11'(i)]), 64'(32'hA000_0010 + 32'(i)));

        $display("[TB] zero length");
        applyStimulus(11'h020, 11'h600, 12'd0, 0, 0, 1'b0, 0, 0);
        checkOutput("zero_done_cycle", 64'(last_done_rel), 64'd1);
        checkOutput("zero_cs_cycles", 64'(cs_seen), 64'd0);
        checkOutput("zero_mem", 64'(ram[11'h600]), 64'hA000_0600);

        $display("[TB] stalls: 2 on first read, 3 on first write");
        applyStimulus(11'h020, 11'h200, 12'd2, 2, 3, 1'b0, 0, 0);
        checkOutput("stall_done_cycle", 64'(last_done_rel), 64'd12);
        checkOutput("stall_mem0", 64'(ram[11'h200]), 64'hA000_0020);
        checkOutput("stall_mem1", 64'(ram[11'h201]), 64'hA000_0021);

        $display("[TB] pointer wrap");
        applyStimulus(11'h7FE, 11'h010, 12'd4, 0, 0, 1'b0, 0, 0);
        exp_wrap = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        checkOutput("wrap_read_count", 64'(rd_log.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("wrap_read_order", 64'((i < rd_log.size()) ? rd_log[i] : 11'h0), 64'(exp_wrap[i]));
        checkOutput("wrap_mem0", 64'(ram[11'h010]), 64'hA000_07FE);
        checkOutput("wrap_mem1", 64'(ram[11'h011]), 64'hA000_07FF);
        checkOutput("wrap_mem2", 64'(ram[11'h012]), 64'hA000_0000);
        checkOutput("wrap_mem3", 64'(ram[11'h013]), 64'hA000_0001);

        $display("[TB] start repeated in cycle 5");
        applyStimulus(11'h030, 11'h300, 12'd4, 0, 0, 1'b0, 5, 0);
        checkOutput("restart_done_cycle", 64'(last_done_rel), 64'd13);
        checkOutput("restart_mem3", 64'(ram[11'h303]), 64'hA000_0033);
        checkOutput("restart_untouched", 64'(ram[11'h500]), 64'hA000_0500);

        $display("[TB] reset in cycle 7 of an 8-word copy");
        applyStimulus(11'h040, 11'h340, 12'd8, 0, 0, 1'b0, 0, 7);
        checkOutput("abort_mem0", 64'(ram[11'h340]), 64'hA000_0040);
        checkOutput("abort_mem1", 64'(ram[11'h341]), 64'hA000_0041);
        checkOutput("abort_mem2", 64'(ram[11'h342]), 64'hA000_0342);
        applyStimulus(11'h050, 11'h350, 12'd3, 0, 0, 1'b0, 0, 0);
        checkOutput("after_reset_done_cycle", 64'(last_done_rel), 64'd10);
        checkOutput("after_reset_mem2", 64'(ram[11'h352]), 64'hA000_0052);

        $display("[TB] random copies with random stalls");
        for (int t = 0; t < 12; t++) begin
            rs = 11'($urandom_range(0, DEPTH - 1));
            rn = 12'($urandom_range(1, 40));
            if (t % 3 == 0)
                rdst = rs + 11'($urandom_range(1, int'(rn)));
            else
                rdst = 11'($urandom_range(0, DEPTH - 1));
            applyStimulus(rs, rdst, rn, 0, 0, 1'b1, 0, 0);
            checkOutput("rand_words_done", 64'(words_done), 64'(rn));
        end

        $display("[TB] full-memory overlapping copy");
        applyStimulus(11'h123, 11'h456, 12'd2048, 0, 0, 1'b0, 0, 0);
        checkOutput("full_words_done", 64'(words_done), 64'd2048);
        checkOutput("full_done_cycle", 64'(last_done_rel), 64'd6145);

        mism = 0;
        for (int i = 0; i < DEPTH; i++)
            if (ram[i] !== mdl[i]) mism++;
        checkOutput("final_memory_mismatches", 64'(mism), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
